// File: rtl/fir_sample_sequencer.sv
// Upstream driver for the 16-tap FIR: buffers samples in a FIFO, issues them one at a
// time, captures each filtered result onto a valid/ack handshake, and watches for a silent FIR.
module fir_sample_sequencer #(
   parameter int unsigned N       = 16,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned TIMEOUT = 32
) (
   input  logic                   ck,
   input  logic                   rst_n,
   input  logic [N-1:0]           in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [N-1:0]           fir_in,
   output logic                   fir_input_ready,
   input  logic [N-1:0]           fir_out,
   input  logic                   fir_output_ready,
   output logic [N-1:0]           res_data,
   output logic                   res_valid,
   input  logic                   res_ack,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [WW-1:0] wd_q, wd_d;
   logic          push, pop, capture, timeout_set;

   assign in_ready = (fifo_count != CW'(DEPTH));
   assign push     = in_valid && in_ready;

   // Sample storage; contents are don't-care until written, so no reset.
   always_ff @(posedge ck) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   // Circular pointers and occupancy; a pushed entry is only poppable from the next cycle.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
      end
   end

   // Next state; a strobe coinciding with the watchdog limit still captures.
   always_comb begin
      state_d     = state_q;
      wd_d        = wd_q;
      pop         = 1'b0;
      capture     = 1'b0;
      timeout_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if ((fifo_count != '0) && !res_valid) begin
               pop     = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_q + WW'(1);
            if (fir_output_ready) begin
               state_d = S_CAPTURE;
            end else if (wd_q == WW'(TIMEOUT - 1)) begin
               timeout_set = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_CAPTURE: begin
            capture = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs derived from the upcoming state and datapath events.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         fir_in          <= '0;
         fir_input_ready <= 1'b0;
         busy            <= 1'b0;
         res_data        <= '0;
         res_valid       <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         fir_input_ready <= (state_d == S_ISSUE);
         busy            <= (state_d != S_IDLE);
         if (pop)         fir_in      <= mem[rd_ptr];
         if (timeout_set) timeout_err <= 1'b1;
         if (capture) begin
            res_data  <= fir_out;
            res_valid <= 1'b1;
         end else if (res_ack) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Self-checking bench: FIR stub, transaction-level reference model and a per-cycle compare.
module tb_fir_sample_sequencer;

   localparam int unsigned N       = 16;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned TIMEOUT = 32;
   localparam int          PH_CAP  = 1000;

   logic                   ck, rst_n;
   logic [N-1:0]           in_data;
   logic                   in_valid, in_ready;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [N-1:0]           fir_in, fir_out, res_data;
   logic                   fir_input_ready, fir_output_ready;
   logic                   res_valid, res_ack, busy, timeout_err;

   fir_sample_sequencer #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .ck(ck), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .fifo_count(fifo_count), .fir_in(fir_in), .fir_input_ready(fir_input_ready),
      .fir_out(fir_out), .fir_output_ready(fir_output_ready), .res_data(res_data),
      .res_valid(res_valid), .res_ack(res_ack), .busy(busy), .timeout_err(timeout_err)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, n_pulse = 0, n_hs = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // 16-tap golden filter: tap 0 weighs 3, later taps small signed weights; N-bit wrap.
   function automatic logic [N-1:0] fir_calc(input logic [N-1:0] h [16]);
      longint acc = 0;
      int     c;
      for (int k = 0; k < 16; k++) begin
         c   = (k == 0) ? 3 : (k % 5) - 2;
         acc += longint'(c) * longint'($signed(h[k]));
      end
      return N'(acc);
   endfunction

   // FIR stub: loads the cycle after the pulse, strobes 17 cycles later, registers out on the strobe edge.
   bit           dead = 0, spur = 0;
   logic         stub_strb;
   logic         s_ld;
   int           s_cnt;
   logic [N-1:0] s_hist [16];
   logic [N-1:0] fir_out_r;

   assign fir_out          = fir_out_r;
   assign fir_output_ready = stub_strb | spur;

   always @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         s_ld <= 1'b0; s_cnt <= 0; stub_strb <= 1'b0; fir_out_r <= '0;
         for (int k = 0; k < 16; k++) s_hist[k] <= '0;
      end else begin
         stub_strb <= 1'b0;
         s_ld      <= fir_input_ready && !dead;
         if (s_ld) begin
            s_hist[0] <= fir_in;
            for (int k = 1; k < 16; k++) s_hist[k] <= s_hist[k-1];
            s_cnt <= 16;
         end else if (s_cnt > 0) begin
            s_cnt <= s_cnt - 1;
            if (s_cnt == 1) stub_strb <= 1'b1;
         end
         if (stub_strb) fir_out_r <= fir_calc(s_hist);
      end
   end

   // Reference model: ph = cycles since the issue pulse (0 idle, PH_CAP capture).
   logic [N-1:0] q [$];
   logic [N-1:0] m_hist [16];
   logic [N-1:0] m_fin, m_rd;
   bit           m_rv, m_terr, m_push;
   int           ph, ph_n;

   always @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         q.delete(); ph = 0; m_fin = '0; m_rd = '0; m_rv = 0; m_terr = 0;
         for (int k = 0; k < 16; k++) m_hist[k] = '0;
      end else begin
         m_push = in_valid && (q.size() != DEPTH);
         ph_n   = ph;
         if (ph == 0) begin
            if (q.size() != 0 && !m_rv) begin
               m_fin = q.pop_front();
               ph_n  = 1;
            end
         end else if (ph == 1) begin
            ph_n = 2;
         end else if (ph == PH_CAP) begin
            for (int k = 15; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_fin;
            m_rd      = fir_calc(m_hist);
            ph_n      = 0;
         end else if (fir_output_ready) begin
            ph_n = PH_CAP;
         end else if (ph - 1 == int'(TIMEOUT)) begin
            m_terr = 1;
            ph_n   = 0;
         end else begin
            ph_n = ph + 1;
         end
         if (ph == PH_CAP) m_rv = 1;
         else if (res_ack) m_rv = 0;
         if (m_push) q.push_back(in_data);
         ph = ph_n;
      end
   end

   always @(posedge ck) begin
      cyc++;
      if (rst_n && fir_input_ready) n_pulse++;
      if (rst_n && res_valid && res_ack) n_hs++;
   end

   // Per-cycle compare of every output against the model.
   always @(negedge ck) begin
      if (rst_n) begin
         chk("fir_input_ready", 32'(fir_input_ready), 32'(ph == 1));
         chk("busy",            32'(busy),            32'(ph != 0));
         chk("res_valid",       32'(res_valid),       32'(m_rv));
         chk("timeout_err",     32'(timeout_err),     32'(m_terr));
         chk("fifo_count",      32'(fifo_count),      32'(q.size()));
         chk("in_ready",        32'(in_ready),        32'(q.size() != DEPTH));
         chk("fir_in",          32'(fir_in),          32'(m_fin));
         chk("res_data",        32'(res_data),        32'(m_rd));
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_fir_in"},      32'(fir_in),          32'h0);
      chk({tag, "_res_data"},    32'(res_data),        32'h0);
      chk({tag, "_fir_irdy"},    32'(fir_input_ready), 32'h0);
      chk({tag, "_res_valid"},   32'(res_valid),       32'h0);
      chk({tag, "_busy"},        32'(busy),            32'h0);
      chk({tag, "_timeout_err"}, 32'(timeout_err),     32'h0);
      chk({tag, "_fifo_count"},  32'(fifo_count),      32'h0);
      chk({tag, "_in_ready"},    32'(in_ready),        32'h1);
   endtask

   // Push n samples (base, base+1, ...) in consecutive cycles; returns on the negedge after the last push edge.
   task automatic push_n(input int n, input logic [N-1:0] base);
      for (int i = 0; i < n; i++) begin
         @(negedge ck);
         in_valid = 1'b1;
         in_data  = base + N'(i);
      end
      @(negedge ck);
      in_valid = 1'b0;
   endtask

   // which: 0 issue pulse, 1 res_valid, 2 timeout_err. Checks the current cycle first.
   task automatic wait_sig(input string nm, input int which, input int budget, output int t);
      int c;
      t = -1;
      c = 0;
      while (t < 0 && c < budget) begin
         if ((which == 0 && fir_input_ready) || (which == 1 && res_valid) ||
             (which == 2 && timeout_err))
            t = cyc;
         else begin
            @(negedge ck);
            c++;
         end
      end
      chk(nm, 32'(t >= 0), 32'h1);
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int c;
      c = 0;
      while ((busy || res_valid || fifo_count != '0) && c < budget) begin
         @(negedge ck);
         c++;
      end
      chk(nm, {29'h0, busy, res_valid, fifo_count != '0}, 32'h0);
   endtask

   int t0, t1, p0, hs0, dl, sent;
   bit pp_pend;

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "global time limit");
   end

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; in_data = '0; res_ack = 1'b0;
      #3 rst_n = 1'b0;
      #1 chk_reset("rst");
      repeat (3) @(negedge ck);
      rst_n = 1'b1;

      // Single impulse with ack tied high.
      res_ack = 1'b1;
      push_n(1, 16'h1234);
      wait_sig("t2_issue", 0, 50, t0);
      chk("t2_fir_in", 32'(fir_in), 32'h1234);
      @(negedge ck);
      wait_sig("t2_result", 1, 60, t1);
      chk("t2_latency", 32'(t1 - t0), 32'd20);
      chk("t2_res_data", 32'(res_data), 32'h369C);

      // Back-to-back throughput.
      push_n(2, 16'h2000);
      wait_sig("t2b_issue1", 0, 5, t0);
      @(negedge ck);
      wait_sig("t2b_issue2", 0, 60, t1);
      chk("t2b_interval", 32'(t1 - t0), 32'd22);
      wait_idle("t2_idle", 100);

      // Fill the FIFO while a result is held unacknowledged.
      res_ack = 1'b0;
      p0 = n_pulse;
      push_n(1, 16'h0A00);
      wait_sig("t3_held", 1, 60, t0);
      push_n(8, 16'h0B00);
      chk("t3_full_count", 32'(fifo_count), 32'd8);
      chk("t3_full_ready", 32'(in_ready), 32'd0);
      repeat (30) @(negedge ck);
      chk("t3_single_issue", 32'(n_pulse - p0), 32'd1);
      res_ack = 1'b1;
      @(negedge ck);
      res_ack = 1'b0;
      wait_sig("t3_resume", 0, 10, t0);
      chk("t3_count_dec", 32'(fifo_count), 32'd7);
      res_ack = 1'b1;
      wait_idle("t3_idle", 400);

      // Hold occupancy at 3 so pushes coincide with pops; 20 samples wrap the pointers.
      sent = 0; pp_pend = 0; dl = cyc + 1500;
      while (sent < 20 && cyc < dl) begin
         @(negedge ck);
         if (pp_pend) begin
            chk("t4_push_pop_hold", 32'(fifo_count), 32'd3);
            pp_pend = 0;
         end
         if (fifo_count < 3 || (fifo_count == 3 && !busy && !res_valid)) begin
            pp_pend  = (fifo_count == 3);
            in_valid = 1'b1;
            in_data  = N'($urandom);
            sent++;
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge ck);
      in_valid = 1'b0;
      if (pp_pend) chk("t4_push_pop_hold", 32'(fifo_count), 32'd3);
      wait_idle("t4_idle", 600);

      // Dead FIR: watchdog, reissue, spurious strobe in IDLE.
      dead = 1;
      push_n(2, 16'h5000);
      wait_sig("t5_issue", 0, 5, t0);
      wait_sig("t5_timeout", 2, 60, t1);
      chk("t5_timeout_delay", 32'(t1 - (t0 + 1)), 32'd32);
      @(negedge ck);
      chk("t5_reissue", 32'(fir_input_ready), 32'd1);
      wait_idle("t5_idle", 60);
      spur = 1;
      @(negedge ck);
      spur = 0;
      repeat (3) @(negedge ck);
      chk("t5_spur_busy", 32'(busy), 32'd0);
      chk("t5_spur_valid", 32'(res_valid), 32'd0);
      dead = 0;

      // Reset during WAIT with three samples queued.
      push_n(4, 16'h6000);
      repeat (4) @(negedge ck);
      chk("t6_queued", 32'(fifo_count), 32'd3);
      #2 rst_n = 1'b0;
      #1 chk_reset("t6");
      @(negedge ck);
      rst_n = 1'b1;
      p0 = n_pulse;
      repeat (40) @(negedge ck);
      chk("t6_no_issue", 32'(n_pulse - p0), 32'd0);
      chk("t6_count", 32'(fifo_count), 32'd0);

      // Random stream with random ack delays.
      res_ack = 1'b0; hs0 = n_hs; sent = 0; dl = cyc + 6000;
      fork
         begin
            while (sent < 64 && cyc < dl) begin
               @(negedge ck);
               if (in_ready && $urandom_range(0, 3) != 0) begin
                  in_valid = 1'b1;
                  in_data  = N'($urandom);
                  sent++;
               end else begin
                  in_valid = 1'b0;
               end
            end
            @(negedge ck);
            in_valid = 1'b0;
         end
         begin
            while (n_hs - hs0 < 64 && cyc < dl) begin
               @(negedge ck);
               res_ack = 1'b0;
               if (res_valid) begin
                  repeat ($urandom_range(0, 5)) @(negedge ck);
                  res_ack = 1'b1;
               end
            end
            @(negedge ck);
            res_ack = 1'b0;
         end
      join
      chk("t7_handshakes", 32'(n_hs - hs0), 32'd64);
      wait_idle("t7_idle", 50);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_sample_sequencer.md
# fir_sample_sequencer

Upstream-side driver for the 16-tap FIR datapath. It buffers incoming samples in a small FIFO and issues them to the FIR one at a time with a single-cycle `fir_input_ready` pulse. It waits for the FIR's `fir_output_ready` strobe, captures the filtered result, and presents it downstream on a valid/ack handshake. A watchdog flags a FIR that never answers.

## Interface
- `N`, 16: sample width. Must match the FIR's `N`.
- `DEPTH`, 8: input FIFO depth in entries. Power of 2, minimum 2.
- `TIMEOUT`, 32: maximum number of cycles spent in WAIT before abandoning a sample. Must be at least 20.

Ports:
- `ck` in 1: clock. Everything is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in N: upstream sample (signed).
- `in_valid` in 1: upstream sample present.
- `in_ready` out 1: FIFO not full. A push occurs when `in_valid && in_ready`.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `fir_in` out N: sample to the FIR. Registered.
- `fir_input_ready` out 1: one-cycle issue pulse to the FIR.
- `fir_out` in N: FIR result.
- `fir_output_ready` in 1: FIR done strobe.
- `res_data` out N: captured result. Registered.
- `res_valid` out 1: result available.
- `res_ack` in 1: downstream consumes the result.
- `busy` out 1: high in ISSUE, WAIT or CAPTURE.
- `timeout_err` out 1: sticky watchdog flag. Cleared only by reset.

## Operation
- FIFO:
  - Circular, depth `DEPTH`, with registered read and write pointers.
  - A push writes to the tail. A pop occurs only on the IDLE→ISSUE transition.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
  - There is no fall-through: a sample pushed in cycle t is eligible for issue from cycle t+1.
  - Pointers wrap modulo `DEPTH`.
  - `in_ready = (fifo_count != DEPTH)`, combinational. A push while full is impossible by construction.
- FSM, states IDLE, ISSUE, WAIT, CAPTURE:
  - IDLE: if `fifo_count != 0` and `res_valid == 0`, load the FIFO head into `fir_in`, pop, and go to ISSUE.
  - ISSUE: `fir_input_ready = 1` for exactly this cycle. Clear the watchdog counter. Go to WAIT.
  - WAIT: increment the watchdog counter each cycle.
    - On `fir_output_ready`, go to CAPTURE.
    - Else, if the counter reaches `TIMEOUT`, set `timeout_err`, drop the sample, and go to IDLE.
    - If `fir_output_ready` and the timeout coincide, `fir_output_ready` wins.
  - CAPTURE: `res_data <= fir_out`, `res_valid <= 1`, then go to IDLE.
- `fir_output_ready` is ignored in every state except WAIT.
- `fir_in` changes only on the IDLE→ISSUE transition. It is held through the FIR's load cycle, which is the cycle after the pulse, and beyond.
- `res_valid` clears on the cycle after `res_ack` is seen high. `res_ack` while `res_valid == 0` is ignored. CAPTURE cannot coincide with `res_valid == 1` because IDLE gates issue on it.
- Data is passed through unmodified (signed N bits). The block does no arithmetic beyond pointer and counter increments.
- Reset behaviour:
  - Reset asserted mid-operation aborts any in-flight sample and empties the FIFO.
  - The FIR reset is system-tied as `rst = ~rst_n`. If the FIR is not reset, its late strobe is ignored per the rule above.

## Timing
- Reset values:
  - `fir_in`, `res_data`: 0.
  - `fir_input_ready`, `res_valid`, `busy`, `timeout_err`: 0.
  - `fifo_count`: 0. `in_ready`: 1.
  - FSM: IDLE.
- Cycle numbering for a single transaction, with cycle 0 being IDLE with the FIFO non-empty and the slot free:
  - Cycle 1: ISSUE, `fir_input_ready` = 1.
  - Cycle 2: the FIR loads `fir_in`.
  - Cycles 3–18: the FIR's 16 processing cycles.
  - Cycle 19: `fir_output_ready` high.
  - Cycle 20: CAPTURE. `fir_out` is valid here; the FIR registers `out` on the strobe edge.
  - Cycle 21: `res_valid` = 1.
- Issue-to-result latency: 20 cycles from the `fir_input_ready` pulse to `res_valid`.
- Back-to-back throughput with immediate `res_ack`: one sample per 22 cycles.
  - Cycle 21: ack.
  - Cycle 22: `res_valid` low, FSM in IDLE.
  - Cycle 23: next ISSUE.
- `fir_input_ready` is never high on two consecutive cycles. Its pulses are separated by at least 20 cycles.
- Timeout on a dead FIR: WAIT is entered in cycle 2 and `timeout_err` rises `TIMEOUT` cycles later (cycle 34 with the default).

## Test plan
- Reset, then push one sample 0x1234 with `res_ack` tied high:
  - `fir_input_ready` pulses once, with `fir_in` = 0x1234.
  - `res_valid` rises 20 cycles after the pulse.
  - `res_data` equals the FIR model output for impulse 0x1234 (tap-0 scaled).
- Push 8 samples in 8 consecutive cycles with `res_ack` held low:
  - `in_ready` drops after the 8th push (`fifo_count` = 8).
  - Exactly one issue occurs; no second issue until ack.
  - After ack, issue resumes and `fifo_count` decrements.
- Push on the same cycle as a pop with `fifo_count` = 3: `fifo_count` stays 3, and pointer wrap-around ordering is preserved across 20 samples.
- Replace the FIR with a stub that never strobes:
  - `timeout_err` rises 32 cycles after WAIT entry.
  - The FSM returns to IDLE and the next sample is issued.
  - A spurious strobe arriving while in IDLE is ignored.
- Assert `rst_n` low during WAIT with 3 samples queued:
  - All outputs return to their reset values immediately.
  - After release, `fifo_count` = 0 and no `fir_input_ready` pulse occurs.
- Stream 64 random samples with random `res_ack` delays (0–5 cycles): output order and values match the golden FIR model, with no drops or duplicates.
